uart_resp_frame_tx: RTL and testbench

//  Response-path framer and UART transmitter for the PWM/DAC command link.
//  - Takes one response record per handshake (function, channel, status, 32-bit data).
//  - Builds a 10-byte frame with header, CRC-8 and footer.
//  - Serialises the frame 8N1, LSB first, on uart_txd.
//  - Sits beside the command receiver/parser; the parser reports command result or readback here.

---
 rtl/uart_resp_frame_tx_if.sv | 28 ++
 rtl/uart_resp_frame_tx.sv | 169 ++++++++++++++++
 tb/tb_uart_resp_frame_tx.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_resp_frame_tx_if.sv
// Response-record handshake between the command parser (master) and the
// response framer (slave). One record is transferred per valid&&ready edge.
interface uart_resp_frame_tx_if;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_func;
    logic [7:0]  resp_ch;
    logic [7:0]  resp_status;
    logic [31:0] resp_data;

    modport master (
        output resp_valid,
        output resp_func,
        output resp_ch,
        output resp_status,
        output resp_data,
        input  resp_ready
    );

    modport slave (
        input  resp_valid,
        input  resp_func,
        input  resp_ch,
        input  resp_status,
        input  resp_data,
        output resp_ready
    );
endinterface

// File: rtl/uart_resp_frame_tx.sv
// Response framer + 8N1 UART transmitter: latches one record and sends
// HEADER func ch status d[31:24] d[23:16] d[15:8] d[7:0] crc8 FOOTER, LSB first.
module uart_resp_frame_tx #(
    parameter int         CLK_FREQ = 50_000_000,
    parameter int         UART_BPS = 115200,
    parameter logic [7:0] HEADER   = 8'h55,
    parameter logic [7:0] FOOTER   = 8'hAA,
    parameter int         GAP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    uart_resp_frame_tx_if.slave  resp,
    output logic                 uart_txd,
    output logic                 tx_busy,
    output logic                 frame_done
);
    localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
    localparam int BAUD_W   = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam int BIT_W    = (GAP_BITS > 8) ? $clog2(GAP_BITS) : 3;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(7);
    localparam logic [BIT_W-1:0]  GAP_LAST  = BIT_W'(GAP_BITS - 1);
    localparam logic [3:0]        LAST_IDX  = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [3:0]          byte_idx;
    logic [7:0]          shift_reg;
    logic [7:0]          crc;
    logic [7:0]          func_q;
    logic [7:0]          ch_q;
    logic [7:0]          status_q;
    logic [31:0]         data_q;
    logic [7:0]          cur_byte;
    logic                accept;
    logic                baud_wrap;
    logic                data_last;
    logic                gap_last;
    logic                crc_covered;

    function automatic logic [7:0] crc8_update(input logic [7:0] crc_in, input logic [7:0] din);
        logic [7:0] c;
        c = crc_in ^ din;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign resp.resp_ready = ~tx_busy & ~sys_rst;
    assign accept          = resp.resp_valid & resp.resp_ready & (state == S_IDLE);
    assign baud_wrap       = (baud_cnt == BAUD_LAST);
    assign data_last       = (bit_cnt == DATA_LAST);
    assign gap_last        = (bit_cnt == GAP_LAST);
    assign crc_covered     = (byte_idx >= 4'd1) && (byte_idx <= 4'd7);

    always_comb begin
        cur_byte = FOOTER;
        case (byte_idx)
            4'd0: cur_byte = HEADER;
            4'd1: cur_byte = func_q;
            4'd2: cur_byte = ch_q;
            4'd3: cur_byte = status_q;
            4'd4: cur_byte = data_q[31:24];
            4'd5: cur_byte = data_q[23:16];
            4'd6: cur_byte = data_q[15:8];
            4'd7: cur_byte = data_q[7:0];
            4'd8: cur_byte = crc;
            default: cur_byte = FOOTER;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = S_LOAD;
            S_LOAD:  next_state = S_START;
            S_START: if (baud_wrap) next_state = S_DATA;
            S_DATA:  if (baud_wrap && data_last) next_state = S_STOP;
            S_STOP:  if (baud_wrap) next_state = (byte_idx == LAST_IDX) ? S_GAP : S_LOAD;
            S_GAP:   if (baud_wrap && gap_last) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // uart_txd is registered from the current state, so the line lags the FSM by
    // one clock; that lag is what puts the start-bit edge two clocks after accept.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            shift_reg  <= '0;
            crc        <= '0;
            func_q     <= '0;
            ch_q       <= '0;
            status_q   <= '0;
            data_q     <= '0;
            uart_txd   <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == S_STOP) && baud_wrap && (byte_idx == LAST_IDX);

            if (accept) begin
                func_q   <= resp.resp_func;
                ch_q     <= resp.resp_ch;
                status_q <= resp.resp_status;
                data_q   <= resp.resp_data;
                crc      <= '0;
                byte_idx <= '0;
                tx_busy  <= 1'b1;
            end

            case (state)
                S_START, S_DATA, S_STOP, S_GAP: baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
                default:                        baud_cnt <= '0;
            endcase

            case (state)
                S_DATA:  if (baud_wrap) bit_cnt <= data_last ? '0 : bit_cnt + 1'b1;
                S_GAP:   if (baud_wrap) bit_cnt <= gap_last ? '0 : bit_cnt + 1'b1;
                default: bit_cnt <= '0;
            endcase

            if (state == S_LOAD) begin
                shift_reg <= cur_byte;
                if (crc_covered) begin
                    crc <= crc8_update(crc, cur_byte);
                end
            end else if (state == S_DATA && baud_wrap) begin
                shift_reg <= {1'b0, shift_reg[7:1]};
            end

            if (state == S_STOP && baud_wrap && byte_idx != LAST_IDX) begin
                byte_idx <= byte_idx + 4'd1;
            end

            if (state == S_GAP && baud_wrap && gap_last) begin
                tx_busy <= 1'b0;
            end

            case (state)
                S_START: uart_txd <= 1'b0;
                S_DATA:  uart_txd <= shift_reg[0];
                default: uart_txd <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_resp_frame_tx.sv
// Self-checking bench for uart_resp_frame_tx: a UART line decoder feeds a byte
// queue that each test compares against bytes pushed when its records are driven.
`timescale 1ns/1ps
module tb_uart_resp_frame_tx;
    localparam int CLK_FREQ   = 1_267_200;
    localparam int UART_BPS   = 115_200;
    localparam int BAUD       = CLK_FREQ / UART_BPS;
    localparam int GAP_BITS   = 1;
    localparam int BYTE_CLKS  = 10 * BAUD + 1;
    localparam int FRAME_CLKS = 10 * BYTE_CLKS;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic uart_txd;
    logic tx_busy;
    logic frame_done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int fd_count    = 0;
    int acc_count   = 0;

    logic [7:0] exp_q[$];
    logic [9:0] rx_q[$];

    uart_resp_frame_tx_if resp_if();

    uart_resp_frame_tx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS),
        .HEADER   (8'h55),
        .FOOTER   (8'hAA),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .resp       (resp_if.slave),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (frame_done === 1'b1) fd_count <= fd_count + 1;
        if (resp_if.resp_valid === 1'b1 && resp_if.resp_ready === 1'b1) acc_count <= acc_count + 1;
    end

    // Line decoder: samples mid-bit on falling clock edges; entry is {start_ok, stop_ok, byte}.
    logic [9:0] rx_word;
    always begin
        @(negedge uart_txd);
        repeat (BAUD / 2) @(negedge sys_clk);
        rx_word[9] = (uart_txd === 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(negedge sys_clk);
            rx_word[i] = uart_txd;
        end
        repeat (BAUD) @(negedge sys_clk);
        rx_word[8] = (uart_txd === 1'b1);
        rx_q.push_back(rx_word);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Bit-serial CRC-8 (poly 0x07, init 0, MSB first).
    function automatic logic [7:0] crc_bits(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r = c;
        for (int i = 7; i >= 0; i--) begin
            logic fb = r[7] ^ b[i];
            r = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return uart_txd;
            1:       return frame_done;
            default: return tx_busy;
        endcase
    endfunction

    task automatic wait_level(input int sel, input logic lvl, input int budget, output bit ok);
        int n = 0;
        while (sel_sig(sel) !== lvl && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        ok = (sel_sig(sel) === lvl);
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic push_record(input logic [7:0] f, input logic [7:0] c, input logic [7:0] s, input logic [31:0] d);
        logic [7:0] crc = 8'h00;
        logic [7:0] b[7];
        b = '{f, c, s, d[31:24], d[23:16], d[15:8], d[7:0]};
        exp_q.push_back(8'h55);
        foreach (b[i]) begin
            exp_q.push_back(b[i]);
            crc = crc_bits(crc, b[i]);
        end
        exp_q.push_back(crc);
        exp_q.push_back(8'hAA);
    endtask

    task automatic drive_record(input logic [7:0] f, input logic [7:0] c, input logic [7:0] s, input logic [31:0] d, input bit push);
        resp_if.resp_func   = f;
        resp_if.resp_ch     = c;
        resp_if.resp_status = s;
        resp_if.resp_data   = d;
        resp_if.resp_valid  = 1'b1;
        if (push) push_record(f, c, s, d);
    endtask

    task automatic test_reset();
        int fd0;
        sys_rst = 1'b1;
        resp_if.resp_valid  = 1'b0;
        resp_if.resp_func   = '0;
        resp_if.resp_ch     = '0;
        resp_if.resp_status = '0;
        resp_if.resp_data   = '0;
        repeat (3) @(negedge sys_clk);
        vectors++;
        if ({uart_txd, resp_if.resp_ready, tx_busy, frame_done} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got txd/ready/busy/done=%b, expected 1000",
                     {uart_txd, resp_if.resp_ready, tx_busy, frame_done});
        end
        sys_rst = 1'b0;
        @(negedge sys_clk);
        fd0 = fd_count;
        for (int i = 0; i < 100; i++) begin
            vectors++;
            if ({uart_txd, resp_if.resp_ready, tx_busy, frame_done} !== 4'b1100) begin
                miscompares++;
                $display("[TB] FAIL idle_outputs cycle %0d: got txd/ready/busy/done=%b, expected 1100",
                         i, {uart_txd, resp_if.resp_ready, tx_busy, frame_done});
            end
            @(negedge sys_clk);
        end
        vectors++;
        if (fd_count !== fd0) begin
            miscompares++;
            $display("[TB] FAIL idle_frame_done: got %0d pulses, expected 0", fd_count - fd0);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] ref_bytes[10];
        logic [9:0] r;
        logic [7:0] e;
        int t_acc, t_fall, t_fd, fd0;
        bit ok;
        ref_bytes = '{8'h55, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h90, 8'hAA};
        foreach (ref_bytes[i]) exp_q.push_back(ref_bytes[i]);
        fd0 = fd_count;
        drive_record(8'h02, 8'h01, 8'h00, 32'h0000_0000, 1'b0);
        @(posedge sys_clk);
        @(negedge sys_clk);
        resp_if.resp_valid = 1'b0;
        t_acc = cyc;
        vectors++;
        if ({uart_txd, resp_if.resp_ready, tx_busy} !== 3'b101) begin
            miscompares++;
            $display("[TB] FAIL accept_flags: got txd/ready/busy=%b, expected 101",
                     {uart_txd, resp_if.resp_ready, tx_busy});
        end
        wait_level(0, 1'b0, 20, ok);
        t_fall = cyc;
        vectors++;
        if (!ok || (t_fall - t_acc) != 2) begin
            miscompares++;
            $display("[TB] FAIL start_latency: got %0d clk (seen=%0b), expected 2", t_fall - t_acc, ok);
        end
        wait_level(0, 1'b1, 3 * BAUD, ok);
        vectors++;
        if (!ok || (cyc - t_fall) != BAUD) begin
            miscompares++;
            $display("[TB] FAIL start_width: got %0d clk, expected %0d", cyc - t_fall, BAUD);
        end
        wait_level(1, 1'b1, FRAME_CLKS + 100, ok);
        t_fd = cyc;
        vectors++;
        if (!ok || (t_fd - t_acc) != FRAME_CLKS) begin
            miscompares++;
            $display("[TB] FAIL frame_length: got %0d clk, expected %0d", t_fd - t_acc, FRAME_CLKS);
        end
        @(negedge sys_clk);
        vectors++;
        if (frame_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL frame_done_width: got %b one cycle later, expected 0", frame_done);
        end
        wait_level(2, 1'b0, 4 * BAUD * GAP_BITS, ok);
        vectors++;
        if (!ok || (cyc - t_fd) != GAP_BITS * BAUD) begin
            miscompares++;
            $display("[TB] FAIL gap_length: got %0d clk, expected %0d", cyc - t_fd, GAP_BITS * BAUD);
        end
        vectors++;
        if (resp_if.resp_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ready_after_gap: got %b, expected 1", resp_if.resp_ready);
        end
        wait_rx(10, 2 * BYTE_CLKS, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL single_rx_count: got %0d bytes, expected 10", rx_q.size());
            rx_q.delete();
            exp_q.delete();
        end else begin
            for (int i = 0; i < 10; i++) begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                vectors++;
                if (r !== {2'b11, e}) begin
                    miscompares++;
                    $display("[TB] FAIL single_byte%0d: got %h (start/stop ok %b), expected %h", i, r[7:0], r[9:8], e);
                end
            end
        end
        vectors++;
        if (rx_q.size() != 0 || fd_count - fd0 != 1) begin
            miscompares++;
            $display("[TB] FAIL single_extra: got %0d extra bytes and %0d frame_done pulses, expected 0 and 1",
                     rx_q.size(), fd_count - fd0);
        end
    endtask

    task automatic test_busy_ignore();
        logic [9:0] r;
        logic [7:0] e;
        int acc0, bad, n;
        bit ok;
        acc0 = acc_count;
        drive_record(8'h01, 8'h02, 8'h00, 32'h1234_5678, 1'b1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        resp_if.resp_valid = 1'b0;
        repeat (3 * BYTE_CLKS) @(negedge sys_clk);
        drive_record(8'h02, 8'h07, 8'h02, 32'hCAFE_F00D, 1'b1);
        bad = 0;
        n   = 0;
        while (tx_busy === 1'b1 && n < FRAME_CLKS + 100) begin
            if (resp_if.resp_ready !== 1'b0) bad++;
            @(negedge sys_clk);
            n++;
        end
        vectors++;
        if (bad != 0 || tx_busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL busy_ready_low: got %0d cycles with ready high, busy=%b; expected 0, 0", bad, tx_busy);
        end
        vectors++;
        if (acc_count - acc0 != 1) begin
            miscompares++;
            $display("[TB] FAIL busy_no_capture: got %0d accepts, expected 1", acc_count - acc0);
        end
        @(negedge sys_clk);
        vectors++;
        if (tx_busy !== 1'b1 || acc_count - acc0 != 2) begin
            miscompares++;
            $display("[TB] FAIL held_accept: got busy=%b accepts=%0d, expected 1 and 2", tx_busy, acc_count - acc0);
        end
        resp_if.resp_valid = 1'b0;
        wait_level(2, 1'b0, FRAME_CLKS + 100, ok);
        wait_rx(20, 2 * BYTE_CLKS, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL busy_rx_count: got %0d bytes, expected 20", rx_q.size());
            rx_q.delete();
            exp_q.delete();
        end else begin
            for (int i = 0; i < 20; i++) begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                vectors++;
                if (r !== {2'b11, e}) begin
                    miscompares++;
                    $display("[TB] FAIL busy_byte%0d: got %h (start/stop ok %b), expected %h", i, r[7:0], r[9:8], e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] r;
        logic [7:0] e;
        int t_fd, fd0;
        bit ok;
        fd0 = fd_count;
        drive_record(8'h03, 8'h04, 8'h01, 32'h0F0F_A5A5, 1'b1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        drive_record(8'h05, 8'hFF, 8'h80, 32'hFFFF_0001, 1'b1);
        wait_level(1, 1'b1, FRAME_CLKS + 100, ok);
        t_fd = cyc;
        wait_level(2, 1'b0, 4 * BAUD * GAP_BITS, ok);
        wait_level(2, 1'b1, 5, ok);
        vectors++;
        if (!ok || (cyc - t_fd) != GAP_BITS * BAUD + 1) begin
            miscompares++;
            $display("[TB] FAIL b2b_spacing: got %0d clk (seen=%0b), expected %0d", cyc - t_fd, ok, GAP_BITS * BAUD + 1);
        end
        resp_if.resp_valid = 1'b0;
        @(negedge sys_clk);
        wait_level(2, 1'b0, FRAME_CLKS + 100, ok);
        wait_rx(20, 2 * BYTE_CLKS, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL b2b_rx_count: got %0d bytes, expected 20", rx_q.size());
            rx_q.delete();
            exp_q.delete();
        end else begin
            for (int i = 0; i < 20; i++) begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                vectors++;
                if (r !== {2'b11, e}) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_byte%0d: got %h (start/stop ok %b), expected %h", i, r[7:0], r[9:8], e);
                end
            end
        end
        vectors++;
        if (rx_q.size() != 0 || fd_count - fd0 != 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_extra: got %0d extra bytes and %0d frame_done pulses, expected 0 and 2",
                     rx_q.size(), fd_count - fd0);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] r;
        logic [7:0] e;
        int fd0;
        bit ok;
        fd0 = fd_count;
        drive_record(8'h11, 8'h03, 8'h00, 32'hDE00_BEEF, 1'b0);
        @(posedge sys_clk);
        @(negedge sys_clk);
        resp_if.resp_valid = 1'b0;
        repeat (5 * BYTE_CLKS + 2 + 4 * BAUD) @(negedge sys_clk);
        vectors++;
        if (uart_txd !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_pre_txd: got %b inside zero payload byte, expected 0", uart_txd);
        end
        sys_rst = 1'b1;
        @(negedge sys_clk);
        vectors++;
        if ({uart_txd, resp_if.resp_ready, tx_busy} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_outputs: got txd/ready/busy=%b, expected 100",
                     {uart_txd, resp_if.resp_ready, tx_busy});
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        vectors++;
        if ({uart_txd, resp_if.resp_ready, tx_busy} !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL rst_release: got txd/ready/busy=%b, expected 110",
                     {uart_txd, resp_if.resp_ready, tx_busy});
        end
        repeat (12 * BAUD) @(negedge sys_clk);
        vectors++;
        if (fd_count != fd0 || uart_txd !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_no_done: got %0d pulses txd=%b, expected 0 and 1", fd_count - fd0, uart_txd);
        end
        rx_q.delete();
        drive_record(8'h01, 8'h05, 8'h01, 32'h8000_0042, 1'b1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        resp_if.resp_valid = 1'b0;
        wait_level(2, 1'b0, FRAME_CLKS + 100, ok);
        wait_rx(10, 2 * BYTE_CLKS, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL rst_rx_count: got %0d bytes, expected 10", rx_q.size());
            rx_q.delete();
            exp_q.delete();
        end else begin
            for (int i = 0; i < 10; i++) begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                vectors++;
                if (r !== {2'b11, e}) begin
                    miscompares++;
                    $display("[TB] FAIL rst_byte%0d: got %h (start/stop ok %b), expected %h", i, r[7:0], r[9:8], e);
                end
            end
        end
    endtask

    task automatic test_random_records();
        logic [9:0] r;
        logic [7:0] e;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            drive_record(8'($urandom), 8'($urandom), 8'($urandom), $urandom, 1'b1);
            @(posedge sys_clk);
            @(negedge sys_clk);
            resp_if.resp_valid = 1'b0;
            wait_level(2, 1'b0, FRAME_CLKS + 100, ok);
            @(negedge sys_clk);
        end
        wait_rx(30, 2 * BYTE_CLKS, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL rand_rx_count: got %0d bytes, expected 30", rx_q.size());
            rx_q.delete();
            exp_q.delete();
        end else begin
            for (int i = 0; i < 30; i++) begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                vectors++;
                if (r !== {2'b11, e}) begin
                    miscompares++;
                    $display("[TB] FAIL rand_byte%0d: got %h (start/stop ok %b), expected %h", i, r[7:0], r[9:8], e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_records();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
